// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
// ---------------------------------------------------------------------------
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard:
// it inhibits the bus, issues a request-to-send, and then shifts the frame
// out on device-generated clock falls. It then checks the device ACK and
// reports the status with a one-cycle done pulse.
//
// Lines are open drain. An asserted *_oe pulls the line low. A deasserted
// *_oe releases the line, and the external pull-up brings it high.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   tx_start     one-cycle request, accepted only while busy = 0
//   tx_data      command byte, latched on an accepted tx_start
//   ps2c_in      PS2 clock line level (asynchronous)
//   ps2d_in      PS2 data line level (asynchronous)
//   ps2c_oe      1 = pull the PS2 clock line low
//   ps2d_oe      1 = pull the PS2 data line low
//   busy         transfer in progress
//   done         one-cycle pulse at the end of every accepted transfer
//   ack_ok       status: the device acknowledged (valid with done)
//   err_noack    status: no ACK on the 11th clock fall (valid with done)
//   err_timeout  status: the transfer exceeded TIMEOUT_CYCLES (valid with done)
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_noack,
  output logic       err_timeout
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning. Index 0 is the clock line and index 1 is the data
  // line. Each line goes through a 2-FF synchronizer and then a stability
  // filter. The filter accepts a new level only after FILTER_LEN
  // consecutive samples that differ from the current filtered level.
  // ---------------------------------------------------------------------
  logic [1:0]    w_lines;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_filt;
  logic          r_c_filt_d;
  logic [FW-1:0] r_fcnt [2];

  assign w_lines = {ps2d_in, ps2c_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_filt     <= 2'b11;
      r_c_filt_d <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        r_fcnt[i] <= '0;
      end
    end else begin
      r_sync1    <= w_lines;
      r_sync2    <= r_sync1;
      r_c_filt_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic w_c_filt;
  logic w_d_filt;
  logic w_fall;

  assign w_c_filt = r_filt[0];
  assign w_d_filt = r_filt[1];
  assign w_fall   = r_c_filt_d & ~r_filt[0];

  // ---------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------
  state_t        r_state;
  logic [9:0]    r_frame;     // {stop, parity, data[7:0]}, shifted out LSB first
  logic [3:0]    r_idx;       // number of falls already served in SEND
  logic [IW-1:0] r_icnt;
  logic [TW-1:0] r_tcnt;
  logic          r_ack_seen;
  logic          w_timeout;

  assign w_timeout = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_idx       <= '0;
      r_icnt      <= '0;
      r_tcnt      <= '0;
      r_ack_seen  <= 1'b0;
      ps2c_oe     <= 1'b0;
      ps2d_oe     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err_noack   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          busy    <= 1'b0;
          if (tx_start) begin
            r_frame     <= {1'b1, ~^tx_data, tx_data};
            r_icnt      <= '0;
            busy        <= 1'b1;
            ps2c_oe     <= 1'b1;
            ack_ok      <= 1'b0;
            err_noack   <= 1'b0;
            err_timeout <= 1'b0;
            r_state     <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_icnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2d_oe <= 1'b1;      // start bit: data low while the clock is still held
            r_state <= S_REQ;
          end else begin
            r_icnt <= r_icnt + 1'b1;
          end
        end

        S_REQ: begin
          ps2c_oe <= 1'b0;        // release the clock; the device now clocks the frame
          r_idx   <= '0;
          r_tcnt  <= '0;
          r_state <= S_SEND;
        end

        S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
          // The timeout is checked first so that it overrides a fall
          // that happens in the same cycle.
          if (w_timeout) begin
            ps2c_oe     <= 1'b0;
            ps2d_oe     <= 1'b0;
            err_timeout <= 1'b1;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_state == S_SEND) begin
              if (w_fall) begin
                ps2d_oe <= ~r_frame[0];
                r_frame <= {1'b0, r_frame[9:1]};
                r_idx   <= r_idx + 1'b1;
                if (r_idx == 4'd9) begin
                  r_state <= S_WAIT_ACK;
                end
              end
            end else if (r_state == S_WAIT_ACK) begin
              if (w_fall) begin
                r_ack_seen <= ~w_d_filt;
                r_state    <= S_WAIT_IDLE;
              end
            end else begin
              if (w_c_filt && w_d_filt) begin
                ack_ok    <= r_ack_seen;
                err_noack <= ~r_ack_seen;
                done      <= 1'b1;
                r_state   <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Directed bench for ps2_host_tx. A keyboard model drives the device side of
// the open-drain lines. Each step checks its result with an immediate
// assertion.
module tb_ps2_host_tx;

  localparam int INH  = 5000;
  localparam int TMO  = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 30;   // keyboard clock half period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err_noack;
  logic       err_timeout;

  logic bfm_c_low = 1'b0;
  logic bfm_d_low = 1'b0;
  logic glitch    = 1'b0;

  int tests = 0;
  int fails = 0;

  // Wired-AND open-drain bus with pull-ups
  assign ps2c_in = ~(ps2c_oe | bfm_c_low | glitch);
  assign ps2d_in = ~(ps2d_oe | bfm_d_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .ps2c_in(ps2c_in),
    .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .busy(busy),
    .done(done),
    .ack_ok(ack_ok),
    .err_noack(err_noack),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue tx_start, measure the inhibit time, and check the REQ cycle and
  // the clock release.
  task automatic start_req(input logic [7:0] d);
    int n;
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    n = 0;
    while (ps2c_oe && !ps2d_oe && n < INH + 10) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("req_c_oe", 32'(ps2c_oe), 1);
    chk("req_d_oe", 32'(ps2d_oe), 1);
    @(negedge clk);
    chk("rel_c_oe", 32'(ps2c_oe), 0);
    chk("rel_d_oe", 32'(ps2d_oe), 1);
  endtask

  // Complete transfer driven by the keyboard model. The frame is sampled on
  // the model's rising edges: start, d0..d7, parity, stop.
  task automatic run_frame(input logic [7:0] d, input logic par, input logic ack,
                           input logic inj_start, input logic inj_glitch);
    logic [10:0] got;
    logic [10:0] exp;
    int n;
    exp = {1'b1, par, d, 1'b0};
    got = '0;
    start_req(d);
    repeat (HALF) @(negedge clk);
    got[0] = ps2d_in;
    for (int k = 1; k <= 10; k++) begin
      bfm_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      bfm_c_low = 1'b0;
      got[k] = ps2d_in;
      if (inj_start && k == 3) begin
        tx_data  = 8'h12;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = d;
      end
      if (inj_glitch && k == 3) begin
        repeat (5) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
      end
      repeat (HALF) @(negedge clk);
    end
    chk("frame_bits", 32'(got), 32'(exp));
    // ACK slot: the device drives data low (or not) around the 11th clock
    bfm_d_low = ack;
    repeat (HALF) @(negedge clk);
    bfm_c_low = 1'b1;
    repeat (HALF) @(negedge clk);
    bfm_c_low = 1'b0;
    bfm_d_low = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_pulse", 32'(done), 1);
    chk("ack_ok", 32'(ack_ok), 32'(ack));
    chk("err_noack", 32'(err_noack), 32'(!ack));
    chk("err_timeout", 32'(err_timeout), 0);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    chk("c_oe_after", 32'(ps2c_oe), 0);
    chk("d_oe_after", 32'(ps2d_oe), 0);
    chk("ack_ok_held", 32'(ack_ok), 32'(ack));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_c_oe", 32'(ps2c_oe), 0);
    chk("rst_d_oe", 32'(ps2d_oe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ack_ok", 32'(ack_ok), 0);
    chk("rst_err_noack", 32'(err_noack), 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1 and parity 1, ACKed
    run_frame(8'hED, 1'b1, 1'b1, 1'b0, 1'b0);
    // Parity corner cases
    run_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    // No ACK from the device on 0xF4 (parity 0)
    run_frame(8'hF4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Device never clocks: a timeout occurs TMO cycles after the clock release
    start_req(8'h55);
    n = 0;
    while (!done && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_len", n, TMO);
    chk("to_err_timeout", 32'(err_timeout), 1);
    chk("to_ack_ok", 32'(ack_ok), 0);
    chk("to_err_noack", 32'(err_noack), 0);
    chk("to_c_oe", 32'(ps2c_oe), 0);
    chk("to_d_oe", 32'(ps2d_oe), 0);
    @(negedge clk);
    chk("to_busy_after", 32'(busy), 0);
    repeat (20) @(negedge clk);

    // A second tx_start during SEND is ignored: the frame is unchanged and there is a single done
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("no_second_xfer", cnt, 0);

    // Reset at fall 5 of 0xED (bit4 = 0 keeps the data line pulled low)
    start_req(8'hED);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      bfm_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      bfm_c_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    bfm_c_low = 1'b1;
    repeat (HALF - 5) @(negedge clk);
    chk("pre_rst_d_oe", 32'(ps2d_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_c_oe", 32'(ps2c_oe), 0);
    chk("midrst_d_oe", 32'(ps2d_oe), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    bfm_c_low = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no_done_after_rst", cnt, 0);
    run_frame(8'hED, 1'b1, 1'b1, 1'b0, 1'b0);

    // A 3-cycle clock glitch during SEND does not advance the bit index
    run_frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
